// File: rtl/adder_pkg.sv
// Shared constants and stage control record for the pipelined ripple-carry adder.
// Optional saturation fields are present only when PIPELINED_RCA_SAT_EN is defined.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Width-independent part of a stage register; the WIDTH-sized sum and
    // pending operand vectors live beside it in the adder itself.
    typedef struct packed {
        logic valid;
        logic carry;
        logic c_msb;
`ifdef PIPELINED_RCA_SAT_EN
        logic sat_mode;
        logic a_sign;
`endif
    } stage_ctrl_t;

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry slice; also exposes the carry into its
// most significant bit so the top slice can derive signed overflow.
module rca_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor, one register per SEG-bit slice, with
// valid/ready backpressure. Define PIPELINED_RCA_SAT_EN for the sat_mode clamp.
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef PIPELINED_RCA_SAT_EN
    input  logic             sat_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             overflow
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    stage_ctrl_t       ctrl_q   [STAGES];
    logic [WIDTH-1:0]  sum_q    [STAGES];
    logic [WIDTH-1:0]  a_q      [STAGES];
    logic [WIDTH-1:0]  b_q      [STAGES];

    stage_ctrl_t       ctrl_src [STAGES];
    logic [WIDTH-1:0]  sum_src  [STAGES];
    logic [WIDTH-1:0]  a_src    [STAGES];
    logic [WIDTH-1:0]  b_src    [STAGES];

    stage_ctrl_t       ctrl_nxt [STAGES];
    logic [WIDTH-1:0]  sum_nxt  [STAGES];
    logic [SEG-1:0]    seg_s    [STAGES];
    logic [STAGES-1:0] seg_c;
    logic [STAGES-1:0] seg_m;
    logic              stall;

    // Bubbles enter as all-zero data so an empty pipe always reads sum=0.
    always_comb begin
        ctrl_src[0]       = '0;
        ctrl_src[0].valid = in_valid;
        ctrl_src[0].carry = in_valid & (sub | cin);
`ifdef PIPELINED_RCA_SAT_EN
        ctrl_src[0].sat_mode = in_valid & sat_mode;
        ctrl_src[0].a_sign   = in_valid & a[WIDTH-1];
`endif
        a_src[0]   = in_valid ? a : '0;
        b_src[0]   = in_valid ? (sub ? ~b : b) : '0;
        sum_src[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            ctrl_src[k] = ctrl_q[k-1];
            a_src[k]    = a_q[k-1];
            b_src[k]    = b_q[k-1];
            sum_src[k]  = sum_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_segment #(.SEG(SEG)) u_seg (
            .a     (a_src[k][k*SEG +: SEG]),
            .b     (b_src[k][k*SEG +: SEG]),
            .cin   (ctrl_src[k].carry),
            .s     (seg_s[k]),
            .cout  (seg_c[k]),
            .c_msb (seg_m[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ctrl_nxt[k]                = ctrl_src[k];
            ctrl_nxt[k].carry          = seg_c[k];
            ctrl_nxt[k].c_msb          = seg_m[k];
            sum_nxt[k]                 = sum_src[k];
            sum_nxt[k][k*SEG +: SEG]   = seg_s[k];
        end
    end

    // A stall freezes every stage at once, so a full pipe never drops a beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                sum_q[k]  <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_nxt[k];
                sum_q[k]  <= sum_nxt[k];
                a_q[k]    <= a_src[k];
                b_q[k]    <= b_src[k];
            end
        end
    end

    assign out_valid = ctrl_q[STAGES-1].valid;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign overflow  = ctrl_q[STAGES-1].carry ^ ctrl_q[STAGES-1].c_msb;

    always_comb begin
        sum = {ctrl_q[STAGES-1].carry, sum_q[STAGES-1]};
`ifdef PIPELINED_RCA_SAT_EN
        if (ctrl_q[STAGES-1].sat_mode && overflow) begin
            sum = {1'b0, ctrl_q[STAGES-1].a_sign, {(WIDTH-1){~ctrl_q[STAGES-1].a_sign}}};
        end
`endif
    end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed self-checking bench for pipelined_rca_adder (WIDTH=32, STAGES=4),
// including backpressure, mid-flight reset and a short random stream.
module tb_pipelined_rca_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef PIPELINED_RCA_SAT_EN
        .sat_mode  (sat_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference arithmetic: subtraction as A-B+2^WIDTH, overflow from operand/result signs.
    function automatic logic [W:0] refSum(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        if (sb) return {1'b0, x} - {1'b0, y} + {1'b1, {W{1'b0}}};
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        logic [W:0] r;
        r = refSum(x, y, ci, sb);
        if (sb) return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    task automatic applyStimulus(input string tag, input logic [W-1:0] opa, input logic [W-1:0] opb,
                                 input logic ci, input logic sb, input logic sm,
                                 input logic [W:0] expSum, input logic expOvf);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = opa;
        b        = opb;
        cin      = ci;
        sub      = sb;
        sat_mode = sm;
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
        sat_mode = 1'b0;
        repeat (S - 2) @(negedge clk);
        checkOutput({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_sum"}, 64'(sum), 64'(expSum));
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(expOvf));
    endtask

    task automatic runStream(input string tag, input int n, input bit rnd);
        logic [W:0]   expQ[$];
        logic         ovfQ[$];
        logic [W:0]   held;
        logic         prevStall;
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic         nc;
        logic         ns;
        int           sent;
        int           got;
        int           cyc;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        prevStall = 1'b0;
        held      = '0;
        na = rnd ? W'($urandom) : W'(0);
        nb = rnd ? W'($urandom) : W'(100);
        nc = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        ns = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        while (got < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 5 && cyc <= 7);
            #1;
            if (prevStall) checkOutput({tag, "_hold"}, 64'(sum), 64'(held));
            if (out_valid && !out_ready) begin
                checkOutput({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
                prevStall = 1'b1;
                held      = sum;
            end else begin
                prevStall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, "_unexpected_beat"}, 64'd1, 64'd0);
                end else begin
                    checkOutput({tag, "_sum"}, 64'(sum), 64'(expQ.pop_front()));
                    checkOutput({tag, "_ovf"}, 64'(overflow), 64'(ovfQ.pop_front()));
                end
                got++;
            end
            if (sent < n) begin
                in_valid = 1'b1;
                a        = na;
                b        = nb;
                cin      = nc;
                sub      = ns;
                if (in_ready) begin
                    expQ.push_back(refSum(na, nb, nc, ns));
                    ovfQ.push_back(refOvf(na, nb, nc, ns));
                    sent++;
                    na = rnd ? W'($urandom) : W'(sent);
                    nb = rnd ? W'($urandom) : W'(100);
                    nc = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    ns = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput({tag, "_count"}, 64'(got), 64'(n));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        sat_mode  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_sum", 64'(sum), 64'd0);
        checkOutput("reset_ovf", 64'(overflow), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        applyStimulus("add_basic",    32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 33'h0_0000_0009, 1'b0);
        applyStimulus("add_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0);
        applyStimulus("sub_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 33'h1_FFFF_FFFE, 1'b0);
        applyStimulus("add_pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1);
        applyStimulus("sub_borrow",   32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 33'h0_FFFF_FFFF, 1'b0);
        applyStimulus("sub_cin_ign",  32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 33'h1_0000_0002, 1'b0);
        applyStimulus("add_neg_ovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 33'h1_0000_0000, 1'b1);
        applyStimulus("sub_neg_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 33'h1_7FFF_FFFF, 1'b1);
`ifdef PIPELINED_RCA_SAT_EN
        applyStimulus("sat_pos",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 33'h0_7FFF_FFFF, 1'b1);
        applyStimulus("sat_neg",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 33'h0_8000_0000, 1'b1);
        applyStimulus("sat_no_ovf",   32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 33'h0_0000_0009, 1'b0);
`endif

        runStream("stream", 8, 1'b0);

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = W'(32'h11 * (i + 1));
            b        = 32'h22;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < S; i++) begin
            checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
            checkOutput("midreset_sum", 64'(sum), 64'd0);
            @(negedge clk);
        end

        applyStimulus("post_reset",   32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 33'h0_2345_6789, 1'b0);

        runStream("random", 200, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
